// File: rtl/io_bus_pkg.sv
// Shared types for the I/O bus master: sequencer states, command record layout
// and the data value returned on a wait-timeout abort.
package io_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_RSP  = 3'd5
    } state_e;

    localparam int CMD_W = 17;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/io_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth so the pointers wrap naturally.
module io_cmd_fifo
    import io_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [CMD_W-1:0]         push_data,
    input  logic                     pop,
    output logic [CMD_W-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop happens on the same edge.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_bus_master.sv
// Z80-style I/O cycle initiator: queues read/write commands and runs one
// IORQ/RD/WR bus cycle at a time, returning one response per command in order.
//
// state | meaning
// IDLE  | strobes high, waiting for a queued command and no pending response
// T1    | address and write data driven, strobes still high
// T2    | IORQ plus RD or WR asserted
// TW    | wait states: minimum count, then wait_n extensions up to the timeout
// T3    | last strobe cycle; read data captured at its exit edge
// RSP   | strobes high, response held until rsp_ready
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int WAIT_STATES  = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_write,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] addr,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] di,
    input  logic       wait_n
);
    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] WS_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [7:0] TMO_LOAD = 8'(WAIT_TIMEOUT);

    state_e           state_q, state_d;
    cmd_t             push_cmd, head_cmd;
    logic [CMD_W-1:0] head_bits;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_count;

    logic             write_q, write_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_oe_q, dout_oe_d;
    logic             iorq_n_q, iorq_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_write_q, rsp_write_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             complete, abort;

    assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign head_cmd = cmd_t'(head_bits);

    io_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign unused_count = ^fifo_count;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        dout_oe_d   = dout_oe_q;
        iorq_n_d    = iorq_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !rsp_valid_q) begin
                    fifo_pop  = 1'b1;
                    write_d   = head_cmd.write;
                    addr_d    = head_cmd.addr;
                    dout_d    = head_cmd.wdata;
                    dout_oe_d = head_cmd.write;
                    state_d   = ST_T1;
                end
            end
            ST_T1: begin
                iorq_n_d = 1'b0;
                rd_n_d   = write_q;
                wr_n_d   = !write_q;
                state_d  = ST_T2;
            end
            ST_T2: begin
                wait_cnt_d = WS_LOAD;
                tmo_cnt_d  = TMO_LOAD;
                if (WAIT_STATES != 0) begin
                    state_d = ST_TW;
                end else if (wait_n) begin
                    state_d = ST_T3;
                end else begin
                    // With no minimum wait, a low wait_n here is already an extension.
                    state_d   = ST_TW;
                    tmo_cnt_d = TMO_LOAD - 8'd1;
                end
            end
            ST_TW: begin
                if (wait_cnt_q != 3'd0) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end else if (wait_n) begin
                    state_d = ST_T3;
                end else if (tmo_cnt_q == 8'd0) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 8'd1;
                end
            end
            ST_T3: begin
                complete = 1'b1;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete || abort) begin
            iorq_n_d    = 1'b1;
            rd_n_d      = 1'b1;
            wr_n_d      = 1'b1;
            dout_oe_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_write_d = write_q;
            rsp_err_d   = abort;
            rsp_rdata_d = abort ? ERR_DATA : (write_q ? 8'h00 : di);
            state_d     = ST_RSP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            dout_q      <= 8'h00;
            dout_oe_q   <= 1'b0;
            iorq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            wait_cnt_q  <= 3'd0;
            tmo_cnt_q   <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
            iorq_n_q    <= iorq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign iorq_n    = iorq_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign addr      = addr_q;
    assign dout      = dout_q;
    assign dout_oe   = dout_oe_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: vector table of single bus cycles plus
// hand sequences for FIFO back-pressure and mid-cycle reset.
module tb_io_bus_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [7:0] rsp_rdata;
    logic       iorq_n, rd_n, wr_n, dout_oe, wait_n;
    logic [7:0] addr, dout, di;

    logic [7:0] io_mem [256];
    int         checks = 0;
    int         errors = 0;

    io_bus_master #(
        .FIFO_DEPTH   (4),
        .WAIT_STATES  (1),
        .WAIT_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .addr      (addr),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .di        (di),
        .wait_n    (wait_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] di;
        int         nwait;
        int         exp_low;
        int         exp_lat;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
    } fcmd_t;

    vec_t  vecs [7];
    fcmd_t fq [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge; the responder drives di while rd_n is low.
    task automatic step();
        @(negedge clk);
        di = (rd_n === 1'b0) ? io_mem[addr] : 8'hEE;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         low_io, low_rd, low_wr, lat;
        bit         seen, addr_bad, data_bad;
        logic       r_wr, r_err;
        logic [7:0] r_rdata;
        low_io = 0; low_rd = 0; low_wr = 0; lat = 0;
        seen = 0; addr_bad = 0; data_bad = 0;
        r_wr = 1'b0; r_err = 1'b0; r_rdata = 8'h00;
        io_mem[v.a] = v.di;
        wait_n    = 1'b1;
        rsp_ready = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.a;
        cmd_wdata = v.wd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            step();
            if (iorq_n === 1'b0) begin
                low_io++;
                if (addr !== v.a) addr_bad = 1;
                if (dout_oe !== v.wr) data_bad = 1;
                if (v.wr && dout !== v.wd) data_bad = 1;
            end
            if (rd_n === 1'b0) low_rd++;
            if (wr_n === 1'b0) low_wr++;
            if (rsp_valid === 1'b1) begin
                seen    = 1;
                lat     = k;
                r_wr    = rsp_write;
                r_err   = rsp_err;
                r_rdata = rsp_rdata;
            end
            wait_n = (!seen && k >= 3 && k < 3 + v.nwait) ? 1'b0 : 1'b1;
        end
        chk($sformatf("v%0d_rsp_seen", idx), 32'(seen), 1);
        chk($sformatf("v%0d_iorq_low", idx), low_io, v.exp_low);
        chk($sformatf("v%0d_rd_low", idx), low_rd, v.wr ? 0 : v.exp_low);
        chk($sformatf("v%0d_wr_low", idx), low_wr, v.wr ? v.exp_low : 0);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_addr_bad", idx), 32'(addr_bad), 0);
        chk($sformatf("v%0d_dout_bad", idx), 32'(data_bad), 0);
        chk($sformatf("v%0d_rsp_write", idx), 32'(r_wr), 32'(v.wr));
        chk($sformatf("v%0d_rsp_rdata", idx), 32'(r_rdata), 32'(v.exp_rdata));
        chk($sformatf("v%0d_rsp_err", idx), 32'(r_err), 32'(v.exp_err));
        step();
        chk($sformatf("v%0d_consumed", idx), 32'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  idx, acc, n_rsp;
        bit  seen, busy, got, f_acc;

        //         wr    addr   wdata  di     nw lo lat rdata  err
        vecs[0] = '{1'b1, 8'h81, 8'h41, 8'h00, 0, 3,  5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h82, 8'h00, 8'h5A, 0, 3,  5, 8'h5A, 1'b0};
        vecs[2] = '{1'b0, 8'h10, 8'h00, 8'hA5, 4, 7,  9, 8'hA5, 1'b0};
        vecs[3] = '{1'b0, 8'h33, 8'h00, 8'h77, 9, 10, 12, 8'hFF, 1'b1};
        vecs[4] = '{1'b1, 8'hFE, 8'h3C, 8'h00, 0, 3,  5, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h44, 8'h00, 8'hC3, 8, 11, 13, 8'hC3, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 8'hFF, 8'h00, 2, 5,  7, 8'h00, 1'b0};

        fq[0] = '{1'b1, 8'h20, 8'h11, 8'h00};
        fq[1] = '{1'b0, 8'h30, 8'h00, 8'h13};
        fq[2] = '{1'b1, 8'h31, 8'h22, 8'h00};
        fq[3] = '{1'b0, 8'h32, 8'h00, 8'hC4};
        fq[4] = '{1'b0, 8'h35, 8'h00, 8'h9E};
        fq[5] = '{1'b1, 8'h34, 8'h66, 8'h00};

        for (int i = 0; i < 256; i++) io_mem[i] = 8'h00;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        wait_n    = 1'b1;
        di        = 8'hEE;

        // Reset state
        step(); step();
        chk("rst_in_iorq_n", 32'(iorq_n), 1);
        chk("rst_in_rsp_valid", 32'(rsp_valid), 0);
        reset = 1'b0;
        step();
        chk("rst_iorq_n", 32'(iorq_n), 1);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_oe", 32'(dout_oe), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_write", 32'(rsp_write), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);

        // Single bus cycles from the vector table
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // FIFO back-pressure: first command parks in RSP, then fill the queue
        for (int i = 0; i < 6; i++) begin
            if (!fq[i].wr) io_mem[fq[i].a] = fq[i].rd;
        end
        rsp_ready = 1'b0;
        wait_n    = 1'b1;
        cmd_write = fq[0].wr;
        cmd_addr  = fq[0].a;
        cmd_wdata = fq[0].wd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (rsp_valid === 1'b1) seen = 1;
        end
        chk("fifo_first_rsp", 32'(seen), 1);

        idx = 1; acc = 0; busy = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 6) begin
                cmd_write = fq[idx].wr;
                cmd_addr  = fq[idx].a;
                cmd_wdata = fq[idx].wd;
                cmd_valid = 1'b1;
            end
            if (cmd_ready === 1'b1 && idx < 6) begin
                acc++;
                idx++;
            end
            if (iorq_n === 1'b0) busy = 1;
            step();
        end
        chk("fifo_accepts", acc, 4);
        chk("fifo_ready_low", 32'(cmd_ready), 0);
        chk("fifo_single_cycle", 32'(busy), 0);
        chk("fifo_rsp_held", 32'(rsp_valid), 1);

        rsp_ready = 1'b1;
        n_rsp = 0; f_acc = 0;
        for (int c = 0; c < 100 && n_rsp < 6; c++) begin
            if (cmd_valid && cmd_ready === 1'b1) f_acc = 1;
            if (rsp_valid === 1'b1) begin
                chk($sformatf("fifo_rsp%0d_write", n_rsp), 32'(rsp_write), 32'(fq[n_rsp].wr));
                chk($sformatf("fifo_rsp%0d_rdata", n_rsp), 32'(rsp_rdata), 32'(fq[n_rsp].rd));
                chk($sformatf("fifo_rsp%0d_err", n_rsp), 32'(rsp_err), 0);
                n_rsp++;
            end
            step();
            if (f_acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("fifo_last_accepted", 32'(f_acc), 1);
        chk("fifo_rsp_count", n_rsp, 6);
        step();

        // Reset asserted during TW of a write, with a second command queued
        rsp_ready = 1'b1;
        wait_n    = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 8'hAA;
        cmd_valid = 1'b1;
        step();
        cmd_addr  = 8'h56;
        cmd_wdata = 8'hBB;
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("rstmid_pre_wr_n", 32'(wr_n), 0);
        chk("rstmid_pre_iorq_n", 32'(iorq_n), 0);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_async_iorq_n", 32'(iorq_n), 1);
        chk("rstmid_async_wr_n", 32'(wr_n), 1);
        chk("rstmid_async_dout_oe", 32'(dout_oe), 0);
        step();
        reset = 1'b0;
        chk("rstmid_cmd_ready", 32'(cmd_ready), 1);
        busy = 0; got = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (iorq_n === 1'b0) busy = 1;
            if (rsp_valid === 1'b1) got = 1;
        end
        chk("rstmid_no_bus_cycle", 32'(busy), 0);
        chk("rstmid_no_response", 32'(got), 0);
        chk("rstmid_cmd_ready_after", 32'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

Synthesizable Z80-style I/O cycle initiator. Accepts read/write commands on a valid/ready port, buffers them in a small FIFO, and drives IORQ/RD/WR bus cycles with T1/T2/TW/T3 timing toward any I/O responder (environment I/O block, peripherals). It returns one response per command, in order. Used as a CPU-less stimulus source and as a host-side bridge onto the tv80 I/O bus.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2
- WAIT_STATES, 1: minimum TW cycles per bus cycle (0..7)
- WAIT_TIMEOUT, 255: max extra TW cycles allowed while wait_n is low before abort (1..255)

Ports (reset is asynchronous, active-high, single clock):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = I/O write, 0 = I/O read
- cmd_addr  in  8  port address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  8  read data; 0x00 for writes; 0xFF on error
- rsp_err  out  1  wait timeout abort
- iorq_n  out  1  I/O request strobe
- rd_n  out  1  read strobe
- wr_n  out  1  write strobe
- addr  out  8  bus address
- dout  out  8  write data
- dout_oe  out  1  dout drive enable
- di  in  8  read data from responder
- wait_n  in  1  responder wait request, low = extend

## Operation
- Push: cmd_valid & cmd_ready at an edge writes {write, addr, wdata} to the FIFO tail. cmd_ready = !full. A push into a full FIFO is not accepted, even if a pop occurs in the same cycle.
- Sequencer FSM states: IDLE, T1, T2, TW, T3, RSP.
- IDLE: if FIFO non-empty and no response is pending, pop the head, latch addr/dout, and go to T1. Otherwise stay in IDLE.
- T1: addr valid; strobes high; dout_oe = write. Next state is T2.
- T2: iorq_n = 0, plus rd_n = 0 (read) or wr_n = 0 (write). If WAIT_STATES = 0, go to T3 when wait_n = 1, else go to TW. For WAIT_STATES > 0, go to TW.
- TW: strobes held. The minimum counter runs WAIT_STATES cycles. In the final minimum cycle and after, wait_n = 0 extends the cycle and increments the timeout counter; wait_n = 1 goes to T3.
- Timeout: when the extension count reaches WAIT_TIMEOUT with wait_n still 0, abort. Strobes go high, rsp_err = 1, rsp_rdata = 0xFF, and the next state is RSP.
- T3: strobes held. At the exiting edge: capture di into rsp_rdata (reads only), deassert all strobes and dout_oe, set rsp_valid, and go to RSP.
- RSP: hold the response until rsp_valid & rsp_ready, then go to IDLE. In-order completion is guaranteed because only one cycle is outstanding.
- Strobes are always high for at least the RSP and IDLE cycles between bus cycles. Responders that detect write completion on the strobe rising edge see exactly one edge per write.
- Reset: asynchronous. All strobes = 1, addr = 0, dout = 0, dout_oe = 0, cmd_ready = 1 (FIFO flushed), rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_err = 0, FSM = IDLE. Reset asserted mid-cycle releases the strobes immediately and drops the command.

## Timing
- All outputs are registered. There is no combinational path from the bus inputs to the outputs.
- Command pushed at edge E0, WAIT_STATES = 1, wait_n = 1:
  - E1: T1
  - E2: T2 (strobes low)
  - E3: TW
  - E4: T3
  - E5: strobes high and rsp_valid = 1
- Strobes are low for exactly 2 + WAIT_STATES cycles plus extensions. Push-to-response latency is 4 + WAIT_STATES + extensions.
- di is sampled only at the T3-exit edge. wait_n is sampled at every TW edge (and at the T2 edge when WAIT_STATES = 0).
- Back-to-back throughput with rsp_ready tied high: one bus cycle per 5 + WAIT_STATES clocks.

## Structure
- Shared package/include io_bus_pkg holds:
  - FSM state encodings
  - the command field layout (width 17: write, addr, wdata)
  - the error data constant 0xFF
- Sub-module io_cmd_fifo holds the synchronous FIFO (parameter DEPTH, width 17, full/empty, count) with asynchronous active-high reset.
- The sequencer FSM, wait/timeout counters and response register live in io_bus_master.

## Test plan
- Write 0x41 to port 0x81, WAIT_STATES = 1, wait_n = 1:
  - wr_n and iorq_n are low E2–E4, addr = 0x81, dout = 0x41, dout_oe = 1.
  - Response at E5: rsp_write = 1, rsp_rdata = 0x00, rsp_err = 0.
- Read port 0x82 with the responder driving di = 0x5A in T3: rd_n is low for 3 cycles; rsp_rdata = 0x5A, rsp_err = 0.
- Hold wait_n low for 4 extra cycles on a read: strobes are low for 7 cycles; the response arrives 4 cycles later than nominal with the correct data.
- WAIT_TIMEOUT = 8 with wait_n stuck low:
  - the abort occurs after 8 extension cycles;
  - rsp_err = 1, rsp_rdata = 0xFF;
  - the next queued command still executes normally.
- Push 5 commands with FIFO_DEPTH = 4 and rsp_ready = 0:
  - cmd_ready drops after 4 accepts;
  - only one bus cycle runs until rsp_ready rises;
  - all responses return in push order.
- Assert reset during TW of a write: strobes go high asynchronously, there is no response, the FIFO is empty, and cmd_ready = 1 after release.
